// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 sliding-window generator: window size,
// controller states and the packed-window bit-offset helper.
package window_pkg;

    localparam int WIN_K = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

    // Bit offset of window element (r,c) inside the packed window bus.
    function automatic int win_idx(input int r, input int c, input int bit_depth);
        return (WIN_K * r + c) * bit_depth;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// 3x3 pixel register array: each enabled cycle shifts the window one column
// left and loads the incoming 3-row column into the rightmost column.
module window_shift_reg
    import window_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               shift_en,
    input  logic [WIN_K*BIT_DEPTH-1:0]         col_in,
    output logic [WIN_K*WIN_K*BIT_DEPTH-1:0]   win_data
);

    logic [BIT_DEPTH-1:0] win_q [WIN_K][WIN_K];

    // NOTE: this array is nine flops, not a RAM, so it takes the async reset
    // and reads back as all-zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN_K; r++) begin
                for (int c = 0; c < WIN_K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (shift_en) begin
            for (int r = 0; r < WIN_K; r++) begin
                for (int c = 0; c < WIN_K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][WIN_K-1] <= col_in[r*BIT_DEPTH +: BIT_DEPTH];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K; c++) begin
                win_data[win_idx(r, c, BIT_DEPTH) +: BIT_DEPTH] = win_q[r][c];
            end
        end
    end

endmodule

// File: rtl/window_gen3x3.sv
// Sliding 3x3 window generator: pops columns from the 3-row linebuffer and
// presents one window per handshake to the downstream MAC stage.
module window_gen3x3
    import window_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 28
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [BIT_DEPTH-1:0]             col_r1,
    input  logic [BIT_DEPTH-1:0]             col_r2,
    input  logic [BIT_DEPTH-1:0]             col_r3,
    output logic                             shift,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [9*BIT_DEPTH-1:0]           win_data,
    output logic [$clog2(COLS)-1:0]          win_col,
    output logic                             busy,
    output logic                             done
);

    localparam int                CNT_W    = $clog2(COLS + 1);
    localparam int                COL_W    = $clog2(COLS);
    localparam logic [CNT_W-1:0]  COLS_CNT = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]  FILL_END = CNT_W'(WIN_K - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  popped;
    logic              handshake;
    logic              last_col;

    assign handshake = win_valid & win_ready;
    assign last_col  = (popped == COLS_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = FILL;
            // The third capture happens on the edge leaving popped == 2.
            FILL: if (popped == FILL_END) state_nxt = RUN;
            RUN:  if (handshake && last_col) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift     = 1'b0;
        win_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: busy = 1'b0;
            FILL: shift = 1'b1;
            RUN: begin
                win_valid = 1'b1;
                shift     = win_ready & ~last_col;
            end
            DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popped  <= '0;
            win_col <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                popped  <= '0;
                win_col <= '0;
            end
        end else begin
            if (shift) begin
                popped <= popped + CNT_W'(1);
            end
            if (state == RUN && shift) begin
                win_col <= win_col + COL_W'(1);
            end
        end
    end

    window_shift_reg #(
        .BIT_DEPTH (BIT_DEPTH)
    ) u_shift_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift),
        .col_in   ({col_r3, col_r2, col_r1}),
        .win_data (win_data)
    );

    no_shift_on_stall: assert property (
        @(posedge clk) disable iff (!rst_n) !(shift && win_valid && !win_ready)
    );

endmodule

// File: tb/tb_window_gen3x3.sv
// Directed bench for window_gen3x3: a COLS=28 instance for the sweep scenarios
// and a COLS=3 instance for the single-window corner case.
module tb_window_gen3x3;

    localparam int BD = 8;

    // Hand-packed windows: element (r,c) at byte 3*r+c, lowest byte first.
    localparam logic [71:0] WIN_FIRST = 72'h20_1F_1E_16_15_14_0C_0B_0A;
    localparam logic [71:0] WIN_COL8  = 72'h28_27_26_1E_1D_1C_14_13_12;
    localparam logic [71:0] WIN_LAST  = 72'h39_38_37_2F_2E_2D_25_24_23;

    logic           clk = 1'b0;
    logic           rst_n;

    logic           start, shift, win_valid, win_ready, busy, done;
    logic [BD-1:0]  col_r1, col_r2, col_r3;
    logic [71:0]    win_data;
    logic [4:0]     win_col;

    logic           start3, shift3, win_valid3, win_ready3, busy3, done3;
    logic [BD-1:0]  col3_r1, col3_r2, col3_r3;
    logic [71:0]    win_data3;
    logic [1:0]     win_col3;

    int src_k, src3_k;
    int n_vec, n_err;
    int n_shift, n_win, n_done, n_stall, done_cyc;

    always #5 clk = ~clk;

    assign col_r1  = BD'(10 + src_k);
    assign col_r2  = BD'(20 + src_k);
    assign col_r3  = BD'(30 + src_k);
    assign col3_r1 = BD'(10 + src3_k);
    assign col3_r2 = BD'(20 + src3_k);
    assign col3_r3 = BD'(30 + src3_k);

    window_gen3x3 #(.BIT_DEPTH(BD), .COLS(28)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .col_r1    (col_r1),
        .col_r2    (col_r2),
        .col_r3    (col_r3),
        .shift     (shift),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_col   (win_col),
        .busy      (busy),
        .done      (done)
    );

    window_gen3x3 #(.BIT_DEPTH(BD), .COLS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .col_r1    (col3_r1),
        .col_r2    (col3_r2),
        .col_r3    (col3_r3),
        .shift     (shift3),
        .win_valid (win_valid3),
        .win_ready (win_ready3),
        .win_data  (win_data3),
        .win_col   (win_col3),
        .busy      (busy3),
        .done      (done3)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window whose leftmost column is c: row r (1..3), column k reads 10*r+k.
    function automatic logic [71:0] win_exp(input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                w[(3*r+j)*BD +: BD] = BD'(10 * (r + 1) + c + j);
            end
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sweep of the COLS=28 instance. stall_col >= 0 holds win_ready low for
    // 5 cycles on that window; restart_cyc >= 0 re-pulses start in that cycle;
    // abort_col >= 0 asserts reset between edges while that window is shown.
    task automatic sweep(input int stall_col, input int restart_cyc, input int abort_col);
        int  cyc;
        int  exp_col;
        int  stall_left;
        logic s, hs;
        src_k    = 0;
        n_shift  = 0;
        n_win    = 0;
        n_done   = 0;
        n_stall  = 0;
        done_cyc = -1;
        exp_col  = 0;
        stall_left = 5;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (cyc < 200) begin
            win_ready = 1'b1;
            if (stall_col >= 0 && win_valid && win_col == 5'(stall_col) && stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end
            start = (cyc == restart_cyc);
            #1;
            if (abort_col >= 0 && win_valid && win_col == 5'(abort_col)) begin
                check("pre_abort_shift", shift, 1);
                rst_n = 1'b0;
                #1;
                check("abort_shift", shift, 0);
                check("abort_valid", win_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_col", win_col, 0);
                check("abort_data", win_data, 0);
                start = 1'b0;
                step();
                rst_n = 1'b1;
                step();
                check("abort_idle_busy", busy, 0);
                return;
            end
            if (cyc < 3) begin
                check("fill_shift", shift, 1);
                check("fill_valid", win_valid, 0);
            end
            if (cyc == 3) check("first_valid", win_valid, 1);
            if (win_valid) begin
                check("win_col", win_col, exp_col);
                check("win_data", win_data, win_exp(exp_col));
                if (win_col == 5'd0)  check("win_first", win_data, WIN_FIRST);
                if (win_col == 5'd8)  check("win_col8", win_data, WIN_COL8);
                if (win_col == 5'd25) check("win_last", win_data, WIN_LAST);
                if (!win_ready) begin
                    check("stall_shift", shift, 0);
                    n_stall++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                n_done++;
            end
            s  = shift;
            hs = win_valid && win_ready;
            step();
            if (s) begin
                src_k++;
                n_shift++;
            end
            if (hs) begin
                n_win++;
                exp_col++;
            end
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc) break;
        end
        start     = 1'b0;
        win_ready = 1'b1;
        #1;
        check("post_done_busy", busy, 0);
        check("post_done_done", done, 0);
    endtask

    task automatic check_basic(input string tag);
        check({tag, "_done_cyc"}, 72'(done_cyc), 29);
        check({tag, "_shifts"}, 72'(n_shift), 28);
        check({tag, "_windows"}, 72'(n_win), 26);
        check({tag, "_done_cnt"}, 72'(n_done), 1);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start3     = 1'b0;
        win_ready  = 1'b1;
        win_ready3 = 1'b1;
        src_k      = 0;
        src3_k     = 0;
        repeat (3) step();

        check("rst_shift", shift, 0);
        check("rst_valid", win_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_col", win_col, 0);
        check("rst_data", win_data, 0);
        check("rst3_shift", shift3, 0);
        check("rst3_data", win_data3, 0);

        rst_n = 1'b1;
        step();
        check("idle_shift", shift, 0);

        // Basic sweep.
        sweep(-1, -1, -1);
        check_basic("basic");
        repeat (2) step();

        // Backpressure on window 7.
        sweep(7, -1, -1);
        check("bp_done_cyc", 72'(done_cyc), 34);
        check("bp_shifts", 72'(n_shift), 28);
        check("bp_windows", 72'(n_win), 26);
        check("bp_stall_cycles", 72'(n_stall), 5);
        check("bp_done_cnt", 72'(n_done), 1);
        repeat (2) step();

        // start pulsed while busy must be ignored.
        sweep(-1, 10, -1);
        check_basic("restart");
        repeat (2) step();

        // Async reset mid-RUN, then a clean sweep from a reloaded source.
        sweep(-1, -1, 12);
        sweep(-1, -1, -1);
        check_basic("after_abort");
        repeat (2) step();

        // COLS=3 instance: three pops, one window, straight to DONE.
        src3_k = 0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("c3_fill_shift", shift3, 1);
            check("c3_fill_valid", win_valid3, 0);
            step();
            src3_k++;
        end
        check("c3_valid", win_valid3, 1);
        check("c3_data", win_data3, WIN_FIRST);
        check("c3_col", win_col3, 0);
        check("c3_last_shift", shift3, 0);
        check("c3_done_early", done3, 0);
        step();
        check("c3_done", done3, 1);
        check("c3_valid_off", win_valid3, 0);
        check("c3_done_shift", shift3, 0);
        step();
        check("c3_done_off", done3, 0);
        check("c3_idle_busy", busy3, 0);
        check("c3_total_pops", 72'(src3_k), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/window_gen3x3.md
Name: window_gen3x3

Overview:
- Sits directly downstream of the 3-row `linebuffer` and pops one 3-row column per cycle from its outputs.
- Assembles a sliding 3x3 pixel window and hands each window to the convolution/MAC stage over a valid/ready handshake.
- Drives the linebuffer `shift` strobe itself, so one `start` pulse sweeps one full row-triple of COLS columns and yields COLS-2 windows.

Parameters:
- BIT_DEPTH, 8, pixel width; must match the linebuffer.
- COLS, 28, columns per row; must match the linebuffer; legal range COLS >= 3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one row sweep; sampled only in IDLE
- col_r1  in  BIT_DEPTH  linebuffer rd_data_r1 (current head column, row 1)
- col_r2  in  BIT_DEPTH  linebuffer rd_data_r2
- col_r3  in  BIT_DEPTH  linebuffer rd_data_r3
- shift  out  1  pop strobe to linebuffer shift; combinational from state, win_valid and win_ready
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  downstream accepts the window this cycle
- win_data  out  9*BIT_DEPTH  packed window; element (r,c) at [(3*r+c)*BIT_DEPTH +: BIT_DEPTH]; r=0..2 maps to rows r1..r3; c=0 is the oldest/leftmost column
- win_col  out  $clog2(COLS)  leftmost column index of the current window, 0..COLS-3
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last window is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE. All of the following are 0: window registers, column counter, win_col, win_valid, done, busy, shift.
- Pop semantics:
  - In any cycle with shift=1, the current col_r1..r3 is captured into window column 2 at the next edge.
  - Columns 2 and 1 move to columns 1 and 0; column 0 is discarded.
  - The linebuffer advances on the same edge.
- Column counter `popped` (0..COLS) increments on every shift.
- IDLE:
  - start=1 → FILL, popped=0. start is ignored in all other states.
  - shift=0, win_valid=0.
- FILL:
  - shift=1 every cycle.
  - After the 3rd capture (popped=3) → RUN with win_valid=1 and win_col=0.
  - Timing: start sampled at edge 0; shift high in cycles 0,1,2; win_valid high from cycle 3.
- RUN:
  - win_valid=1 throughout.
  - win_data and win_col are held stable while win_ready=0; there is no shift while stalled.
  - Handshake (win_valid & win_ready) with popped<COLS: shift=1 that cycle. The next window appears the following cycle, win_col increments, and win_valid stays 1. Throughput is 1 window/cycle with win_ready tied high.
  - Handshake with popped==COLS: shift=0; go to DONE; win_valid=0 next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 from that IDLE cycle.
- Totals per sweep:
  - Exactly COLS shifts and COLS-2 windows.
  - Minimum duration is COLS+1 cycles from the start-sampling edge to the done cycle, with win_ready=1.
- COLS=3: FILL → RUN produces a single window; its handshake goes straight to DONE.
- Reset mid-sweep: immediate abort to IDLE, shift drops asynchronously, and no done pulse. The linebuffer's partial pop is not undone; the controller upstream owns reload.
- win_ready in IDLE, FILL or DONE is don't-care.
- Assertion: shift never high while win_valid=1 and win_ready=0.

Decomposition:
- Package window_pkg holds:
  - WIN_K=3
  - state enum {IDLE, FILL, RUN, DONE}
  - function win_idx(r,c) returning the packed bit offset
- Sub-module window_shift_reg (parameter BIT_DEPTH) holds the 3x3 register array, a shift-in enable and the packed output.
- The FSM and counters stay in window_gen3x3.

Test Plan:
- Source model: the bench models the linebuffer as a pop-on-shift queue where row r (1..3) column k gives 10*r+k. COLS=28, win_ready=1.
- Basic sweep: pulse start → shift high 3 cycles, then win_valid at cycle 3. First window is r1={10,11,12}, r2={20,21,22}, r3={30,31,32}, win_col=0. There are 26 consecutive windows, the last is win_col=25 with r1={35,36,37}, 28 shifts total, and done pulses once at cycle 29.
- Backpressure: drop win_ready for 5 cycles at win_col=7 → win_data and win_col frozen, shift=0 throughout. Resumes at win_col=8 on r1={18,19,20}, with total shift count still 28.
- Start while busy: pulse start again at cycle 10 → ignored. Window count 26, one done pulse.
- Async reset mid-RUN at win_col=12 (between edges) → shift, win_valid and busy drop at once; all outputs are 0. A following start sweep behaves exactly like the basic sweep with a reloaded source.
- COLS=3 build: start → 3 shifts, one window r1={10,11,12}, win_col=0. Accepted with win_ready=1, done pulses the next cycle.
